rcas_seq_nbit: RTL and testbench

Parametrised, multi-cycle ripple-carry adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock, chaining the carry between cycles through a register. It succeeds the fixed-width combinational add/sub units in the arithmetic-logic library. It trades latency for a DIGIT-bit adder instead of a full WIDTH-bit carry chain. It adds valid/ready handshakes and status flags (carry, signed overflow, zero, negative) for use behind sequencers and datapath controllers.

---
 rtl/rcas_seq_nbit.sv | 124 ++++++++++++
 tb/tb_rcas_seq_nbit.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcas_seq_nbit.sv
// Digit-serial ripple-carry adder/subtractor: DIGIT bits per clock,
// carry chained between cycles, valid/ready on both sides.
module rcas_seq_nbit #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("rcas_seq_nbit: WIDTH must be >= 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("rcas_seq_nbit: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic             sel_lat;
    logic             carry;
    logic [KW-1:0]    k;

    logic [DIGIT-1:0] a_sl;
    logic [DIGIT-1:0] b_sl;
    logic [DIGIT:0]   sum;
    logic [DIGIT-1:0] s;
    logic             cy;
    logic             c_msb;

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                a_sl = a_lat[i*DIGIT +: DIGIT];
                b_sl = b_lat[i*DIGIT +: DIGIT] ^ {DIGIT{sel_lat}};
            end
        end
        sum   = {1'b0, a_sl} + {1'b0, b_sl} + {{DIGIT{1'b0}}, carry};
        s     = sum[DIGIT-1:0];
        cy    = sum[DIGIT];
        // carry into the slice MSB recovered from its sum bit
        c_msb = a_sl[DIGIT-1] ^ b_sl[DIGIT-1] ^ s[DIGIT-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_lat     <= '0;
            b_lat     <= '0;
            sel_lat   <= 1'b0;
            carry     <= 1'b0;
            k         <= '0;
            result    <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_lat   <= a;
                        b_lat   <= b;
                        sel_lat <= sel;
                        carry   <= sel;
                        k       <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    for (int i = 0; i < N; i++) begin
                        if (k == KW'(i)) begin
                            result[i*DIGIT +: DIGIT] <= s;
                        end
                    end
                    carry <= cy;
                    k     <= k + 1'b1;
                    if (k == K_LAST) begin
                        c_out     <= cy;
                        ovf       <= c_msb ^ cy;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign zero     = (result == '0);
    assign neg      = result[WIDTH-1];

endmodule

// File: tb/tb_rcas_seq_nbit.sv
// Scoreboard bench for rcas_seq_nbit: 32/8 directed + random,
// 16/4 and 8/8 random against a wide reference model.
module tb_rcas_seq_nbit;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        o;
        logic        z;
        logic        n;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic        rst_s[3];
    logic        in_valid_s[3];
    logic        in_ready_s[3];
    logic [31:0] a_s[3];
    logic [31:0] b_s[3];
    logic        sel_s[3];
    logic        out_valid_s[3];
    logic        out_ready_s[3];
    logic        c_s[3];
    logic        o_s[3];
    logic        z_s[3];
    logic        n_s[3];
    logic [31:0] r0;
    logic [15:0] r1;
    logic [7:0]  r2;

    int nsl[3] = '{4, 4, 1};
    int wid[3] = '{32, 16, 8};

    rcas_seq_nbit #(.WIDTH(32), .DIGIT(8)) u_w32 (
        .clk(clk), .rst(rst_s[0]),
        .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
        .a(a_s[0]), .b(b_s[0]), .sel(sel_s[0]),
        .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]),
        .result(r0), .c_out(c_s[0]), .ovf(o_s[0]),
        .zero(z_s[0]), .neg(n_s[0])
    );

    rcas_seq_nbit #(.WIDTH(16), .DIGIT(4)) u_w16 (
        .clk(clk), .rst(rst_s[1]),
        .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
        .a(a_s[1][15:0]), .b(b_s[1][15:0]), .sel(sel_s[1]),
        .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]),
        .result(r1), .c_out(c_s[1]), .ovf(o_s[1]),
        .zero(z_s[1]), .neg(n_s[1])
    );

    rcas_seq_nbit #(.WIDTH(8), .DIGIT(8)) u_w8 (
        .clk(clk), .rst(rst_s[2]),
        .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
        .a(a_s[2][7:0]), .b(b_s[2][7:0]), .sel(sel_s[2]),
        .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]),
        .result(r2), .c_out(c_s[2]), .ovf(o_s[2]),
        .zero(z_s[2]), .neg(n_s[2])
    );

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    function automatic exp_t mk(logic [31:0] r, logic c, logic o,
                                logic z, logic n);
        exp_t e;
        e.r = r;
        e.c = c;
        e.o = o;
        e.z = z;
        e.n = n;
        return e;
    endfunction

    // Reference: (w+1)-bit sum; overflow from operand/result signs.
    function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b,
                                   logic sel);
        logic [33:0] full;
        logic [31:0] m;
        logic [31:0] aa;
        logic [31:0] bb;
        logic [31:0] rr;
        exp_t        e;
        m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        aa   = a & m;
        bb   = (sel ? ~b : b) & m;
        full = {2'b00, aa} + {2'b00, bb} + {33'd0, sel};
        rr   = full[31:0] & m;
        e.r  = rr;
        e.c  = full[w];
        e.o  = (aa[w-1] == bb[w-1]) && (rr[w-1] != aa[w-1]);
        e.z  = (rr == 32'd0);
        e.n  = rr[w-1];
        return e;
    endfunction

    function automatic exp_t got(int id);
        exp_t e;
        case (id)
            0:       e = {r0, c_s[0], o_s[0], z_s[0], n_s[0]};
            1:       e = {16'h0, r1, c_s[1], o_s[1], z_s[1], n_s[1]};
            default: e = {24'h0, r2, c_s[2], o_s[2], z_s[2], n_s[2]};
        endcase
        return e;
    endfunction

    function automatic void push(int id, exp_t e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop(int id);
        case (id)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: compare on every output handshake, measure latency.
    int   acc_cyc[3];
    int   val_cyc[3];
    bit   seen[3];
    exp_t me;
    exp_t mg;
    int   lat;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_s[i]) begin
                seen[i] = 1'b0;
            end else begin
                if (in_valid_s[i] && in_ready_s[i]) acc_cyc[i] = cyc;
                if (out_valid_s[i] && !seen[i]) begin
                    seen[i]    = 1'b1;
                    val_cyc[i] = cyc;
                end
                if (out_valid_s[i] && out_ready_s[i]) begin
                    seen[i] = 1'b0;
                    tests++;
                    if (qsize(i) == 0) begin
                        fails++;
                        $display("FAIL unexpected_out[%0d] got result=%h, required no output",
                                 i, got(i).r);
                    end else begin
                        me = pop(i);
                        mg = got(i);
                        if (mg !== me) begin
                            fails++;
                            $display("FAIL result[%0d] got r=%h c=%b o=%b z=%b n=%b, required r=%h c=%b o=%b z=%b n=%b",
                                     i, mg.r, mg.c, mg.o, mg.z, mg.n,
                                     me.r, me.c, me.o, me.z, me.n);
                        end
                        tests++;
                        lat = val_cyc[i] - acc_cyc[i] - 1;
                        if (lat != nsl[i]) begin
                            fails++;
                            $display("FAIL latency[%0d] got %0d, required %0d",
                                     i, lat, nsl[i]);
                        end
                    end
                end
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after the accept edge.
    task automatic op(int id, logic [31:0] a, logic [31:0] b, logic sel,
                      exp_t e, bit chk);
        int n;
        n = 0;
        while (!in_ready_s[id]) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL ready_timeout[%0d] got in_ready=0, required 1 within 200 cycles",
                         id);
                return;
            end
        end
        a_s[id]        = a;
        b_s[id]        = b;
        sel_s[id]      = sel;
        in_valid_s[id] = 1'b1;
        if (chk) push(id, e);
        @(posedge clk);
        #1;
        in_valid_s[id] = 1'b0;
        a_s[id]        = $urandom;
        b_s[id]        = $urandom;
        sel_s[id]      = 1'($urandom);
    endtask

    task automatic check(string name, logic [39:0] g, logic [39:0] r);
        tests++;
        if (g !== r) begin
            fails++;
            $display("FAIL %s got %h, required %h", name, g, r);
        end
    endtask

    task automatic run_directed();
        int          n;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        out_ready_s[0] = 1'b1;
        op(0, 32'h0000_00FF, 32'h1, 1'b0, mk(32'h0000_0100, 0, 0, 0, 0), 1);
        op(0, 32'h5, 32'h5, 1'b1, mk(32'h0, 1, 0, 1, 0), 1);
        op(0, 32'h3, 32'h5, 1'b1, mk(32'hFFFF_FFFE, 0, 0, 0, 1), 1);
        op(0, 32'h7FFF_FFFF, 32'h1, 1'b0, mk(32'h8000_0000, 0, 1, 0, 1), 1);
        op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, mk(32'h0, 1, 0, 1, 0), 1);
        op(0, 32'h8000_0000, 32'h1, 1'b1, mk(32'h7FFF_FFFF, 1, 1, 0, 0), 1);

        // Backpressure: hold result in DONE while new operands are offered.
        op(0, 32'h10, 32'h20, 1'b0, mk(32'h30, 0, 0, 0, 0), 1);
        out_ready_s[0] = 1'b0;
        n = 0;
        while (!out_valid_s[0] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_valid_wait", {39'd0, out_valid_s[0]}, 40'd1);
        for (int j = 0; j < 10; j++) begin
            in_valid_s[0] = 1'b1;
            a_s[0]        = 32'hDEAD_0000 + j;
            b_s[0]        = 32'h0BAD_F00D;
            sel_s[0]      = 1'b1;
            @(negedge clk);
            check("bp_hold", {2'b00, got(0), in_ready_s[0], out_valid_s[0]},
                  {2'b00, mk(32'h30, 0, 0, 0, 0), 1'b0, 1'b1});
            @(posedge clk);
            #1;
        end
        in_valid_s[0]  = 1'b0;
        out_ready_s[0] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_release", {38'd0, in_ready_s[0], out_valid_s[0]},
              {38'd0, 1'b1, 1'b0});
        @(posedge clk);
        #1;

        // Reset in the second CALC cycle discards the operation.
        op(0, 32'h1, 32'h2, 1'b0, mk(32'h3, 0, 0, 0, 0), 0);
        @(posedge clk);
        #1;
        rst_s[0] = 1'b1;
        @(posedge clk);
        #1;
        rst_s[0] = 1'b0;
        @(negedge clk);
        check("mid_reset", {2'b00, got(0), out_valid_s[0], in_ready_s[0]},
              {2'b00, mk(32'h0, 0, 0, 1, 0), 1'b0, 1'b1});
        @(posedge clk);
        #1;
        op(0, 32'h1234_5678, 32'h1111_1111, 1'b0,
           mk(32'h2345_6789, 0, 0, 0, 0), 1);

        for (int j = 0; j < 200; j++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            op(0, ra, rb, rs, model(32, ra, rb, rs), 1);
        end
    endtask

    task automatic run_random(int id);
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        for (int j = 0; j < 1000; j++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            if (j % 16 == 0) ra = 32'hFFFF_FFFF;
            if (j % 16 == 1) rb = 32'h0;
            op(id, ra, rb, rs, model(wid[id], ra, rb, rs), 1);
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready_s[1] = ($urandom % 4) != 0;
        out_ready_s[2] = ($urandom % 3) != 0;
    end

    initial begin
        int n;
        for (int i = 0; i < 3; i++) begin
            rst_s[i]      = 1'b1;
            in_valid_s[i] = 1'b0;
            a_s[i]        = '0;
            b_s[i]        = '0;
            sel_s[i]      = 1'b0;
            seen[i]       = 1'b0;
            acc_cyc[i]    = 0;
            val_cyc[i]    = 0;
        end
        out_ready_s[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_state[%0d]", i),
                  {2'b00, got(i), out_valid_s[i], in_ready_s[i]},
                  {2'b00, mk(32'h0, 0, 0, 1, 0), 1'b0, 1'b1});
        end
        @(posedge clk);
        #1;
        fork
            run_directed();
            run_random(1);
            run_random(2);
        join
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("drain", {8'd0, 32'(q0.size() + q1.size() + q2.size())}, 40'd0);
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
